// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: operation request / HI-LO bus between the pipeline and the
// multiply-divide unit.
//   start, op, a, b     - operation request (op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   mthi, mtlo, wdata   - direct HI/LO writes (MTHI/MTLO)
//   hi, lo              - architectural HI/LO (MFHI/MFLO source)
//   busy, done          - stall request and completion pulse
interface hilo_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (output start, op, a, b, mthi, mtlo, wdata,
                  input  hi, lo, busy, done);
  modport slave  (input  start, op, a, b, mthi, mtlo, wdata,
                  output hi, lo, busy, done);
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32x32 multiply / divide unit owning HI and LO.
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset (aborts any operation)
//   bus  - hilo_muldiv_if.slave: request, MTHI/MTLO, HI/LO, busy, done
// One operation takes 32 CALC cycles of shift-add (multiply) or restoring
// shift-subtract (divide) on operand magnitudes, then one FIX cycle that
// applies signs and writes HI/LO.
module hilo_muldiv (
  input  logic         clk,
  input  logic         rst,
  hilo_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;       // raw dividend, returned as HI on divide-by-zero
  logic [31:0] m_q;       // |a| for multiply, |b| for divide
  logic [63:0] w_q;       // mul: {acc, multiplier}; div: {rem, dividend/quotient}
  logic        neg_lo_q;  // negate product / quotient
  logic        neg_hi_q;  // negate remainder
  logic        bz_q;      // divisor was zero
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  // request decode and operand magnitudes
  logic        accept;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;

  assign accept = (state_q == IDLE) && bus.start;
  assign a_neg  = bus.op[0] & bus.a[31];
  assign b_neg  = bus.op[0] & bus.b[31];
  assign abs_a  = a_neg ? -bus.a : bus.a;
  assign abs_b  = b_neg ? -bus.b : bus.b;

  // one iteration of each algorithm
  logic [32:0] mul_sum;
  logic [63:0] mul_w;
  logic [32:0] div_sh, div_diff;
  logic [63:0] div_w;

  always_comb begin
    mul_sum  = {1'b0, w_q[63:32]} + (w_q[0] ? {1'b0, m_q} : 33'd0);
    mul_w    = {mul_sum, w_q[31:1]};
    div_sh   = {w_q[63:32], w_q[31]};
    div_diff = div_sh - {1'b0, m_q};
    // borrow out means the trial subtraction failed: restore
    div_w    = div_diff[32] ? {div_sh[31:0],   w_q[30:0], 1'b0}
                            : {div_diff[31:0], w_q[30:0], 1'b1};
  end

  // sign correction; divide-by-zero bypasses it entirely
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    prod = neg_lo_q ? -w_q : w_q;
    if (!op_q[1]) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (bz_q) begin
      res_hi = a_q;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      res_hi = neg_hi_q ? -w_q[63:32] : w_q[63:32];
      res_lo = neg_lo_q ? -w_q[31:0]  : w_q[31:0];
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)      state_d = CALC;
      CALC:    if (cnt_q == 6'd31) state_d = FIX;
      FIX:                         state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      m_q      <= 32'd0;
      w_q      <= 64'd0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          // MT writes land first; a coincident operation overwrites at FIX
          if (bus.mthi) hi_q <= bus.wdata;
          if (bus.mtlo) lo_q <= bus.wdata;
          if (accept) begin
            op_q     <= bus.op;
            a_q      <= bus.a;
            bz_q     <= (bus.b == 32'd0);
            cnt_q    <= 6'd0;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= bus.op[1] & a_neg;
            if (bus.op[1]) begin
              w_q <= {32'd0, abs_a};
              m_q <= abs_b;
            end else begin
              w_q <= {32'd0, abs_b};
              m_q <= abs_a;
            end
          end
        end
        CALC: begin
          w_q   <= op_q[1] ? div_w : mul_w;
          cnt_q <= cnt_q + 6'd1;
        end
        FIX: begin
          hi_q  <= res_hi;
          lo_q  <= res_lo;
          cnt_q <= 6'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule
